// File: rtl/cmp_seq_pkg.sv
// cmp_seq_pkg: shared types and constants for the serial nibble comparator.
// Build option: define CMP_SEQ_EARLY_EXIT_EN to stop scanning at the first
// unequal nibble; by default every nibble is scanned (constant latency).
package cmp_seq_pkg;

    // Width of one comparison slice
    localparam int NIBBLE_W = 4;

    // Control FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Registered comparison outcome, exactly one bit set when valid
    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } result_t;

endpackage

// File: rtl/cmp_nibble.sv
// cmp_nibble: combinational 4-bit unsigned magnitude comparator.
// This is the only comparison logic in cmp_seq; it is time-shared across nibbles.
module cmp_nibble
    import cmp_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    output logic                g,
    output logic                e,
    output logic                l
);

    // Magnitude relations of the presented nibble pair
    always_comb begin
        g = (a > b);
        e = (a == b);
        l = (a < b);
    end

endmodule

// File: rtl/cmp_seq.sv
// cmp_seq: sequential unsigned comparator, one nibble per cycle, MSB nibble first.
// Build option: CMP_SEQ_EARLY_EXIT_EN leaves the scan at the first unequal
// nibble; when undefined the scan always covers all NIBBLES nibbles.
module cmp_seq
    import cmp_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0]  a,
    input  logic [NIBBLE_W*NIBBLES-1:0]  b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         gt,
    output logic                         eq,
    output logic                         lt,
    output logic                         busy
);

    localparam int               IDX_W   = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(NIBBLES - 1);

    state_t                            r_state;
    state_t                            w_state_nxt;
    logic [IDX_W-1:0]                  r_idx;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]  r_a;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]  r_b;
    result_t                           r_res;
    logic                              r_found;
    logic                              r_found_gt;

    logic [NIBBLE_W-1:0]               w_a_nib;
    logic [NIBBLE_W-1:0]               w_b_nib;
    logic                              w_g;
    logic                              w_e;
    logic                              w_l;
    logic                              w_accept;
    logic                              w_last;
    logic                              w_exit;
    result_t                           w_res_now;

    // Select the nibble pair addressed by the scan index
    always_comb begin
        w_a_nib = r_a[r_idx];
        w_b_nib = r_b[r_idx];
    end

    cmp_nibble u_cmp (
        .a (w_a_nib),
        .b (w_b_nib),
        .g (w_g),
        .e (w_e),
        .l (w_l)
    );

    // Handshake qualifiers and scan termination condition
    always_comb begin
        w_accept = in_valid && (r_state == IDLE);
        w_last   = (r_idx == '0);
`ifdef CMP_SEQ_EARLY_EXIT_EN
        w_exit   = w_last || !w_e;
`else
        w_exit   = w_last;
`endif
    end

    // Final result: the first unequal nibble seen (earlier cycle or this one) wins
    always_comb begin
        w_res_now = '0;
        if (r_found) begin
            w_res_now.gt = r_found_gt;
            w_res_now.lt = !r_found_gt;
        end else begin
            w_res_now.gt = w_g;
            w_res_now.eq = w_e;
            w_res_now.lt = w_l;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and handshake/status outputs
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        busy        = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = CMP;
                end
            end
            CMP: begin
                busy = 1'b1;
                if (w_exit) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand latch and MSB-first scan index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_idx <= '0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_idx <= IDX_MSB;
        end else if ((r_state == CMP) && !w_last) begin
            r_idx <= r_idx - IDX_W'(1);
        end
    end

    // Remember the most significant unequal nibble while the scan continues
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_found    <= 1'b0;
            r_found_gt <= 1'b0;
        end else if (w_accept) begin
            r_found    <= 1'b0;
            r_found_gt <= 1'b0;
        end else if ((r_state == CMP) && !r_found && !w_e) begin
            r_found    <= 1'b1;
            r_found_gt <= w_g;
        end
    end

    // Result register, updated only on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res <= '0;
        end else if ((r_state == CMP) && w_exit) begin
            r_res <= w_res_now;
        end
    end

    assign gt = r_res.gt;
    assign eq = r_res.eq;
    assign lt = r_res.lt;

    // Presented result is one-hot and held until the consumer takes it
    a_onehot : assert property (@(posedge clk) disable iff (!rst_n)
        out_valid |-> $onehot({gt, eq, lt}));
    a_hold : assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable({gt, eq, lt})));

endmodule

// File: tb/tb_cmp_seq.sv
// tb_cmp_seq: directed scoreboard bench for cmp_seq (NIBBLES=4).
// The driver pushes expected results on each accept; a negedge monitor pops
// and checks result, one-hotness, latency and hold stability.
module tb_cmp_seq;

    localparam int N = 4;
    localparam int W = 4 * N;
    localparam logic [2:0] R_GT = 3'b100;
    localparam logic [2:0] R_EQ = 3'b010;
    localparam logic [2:0] R_LT = 3'b001;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         gt, eq, lt, busy;

    always #5 clk = ~clk;

    cmp_seq #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gt        (gt),
        .eq        (eq),
        .lt        (lt),
        .busy      (busy)
    );

    typedef struct {
        logic [2:0] res;
        int         lat;
        int         acc;
    } exp_t;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [2:0]   res;
        int           lat_early;
        int           lat_full;
    } vec_t;

    // Hand-computed vectors: {a, b, {gt,eq,lt}, latency early-exit, latency full}
    vec_t vt [9] = '{
        '{16'h1234, 16'h1234, R_EQ, 4, 4},
        '{16'h8000, 16'h7FFF, R_GT, 1, 4},
        '{16'h1230, 16'h1231, R_LT, 4, 4},
        '{16'h0000, 16'hFFFF, R_LT, 1, 4},
        '{16'hFFFF, 16'hFFFE, R_GT, 4, 4},
        '{16'h1334, 16'h1234, R_GT, 2, 4},
        '{16'hABCD, 16'hABDD, R_LT, 3, 4},
        '{16'h0F00, 16'h0E00, R_GT, 2, 4},
        '{16'hFFFF, 16'hFFFF, R_EQ, 4, 4}
    };

    exp_t sb_q [$];
    exp_t cur;
    logic seen = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_out = 0;
    int   last_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lat_of(input vec_t v);
`ifdef CMP_SEQ_EARLY_EXIT_EN
        return v.lat_early;
`else
        return v.lat_full;
`endif
    endfunction

    // Monitor: check each presented result once, then its stability while held
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
        end else if (out_valid) begin
            if (!seen) begin
                n_out++;
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_result: out_valid with nothing pending, gt/eq/lt=%b", {gt, eq, lt});
                    cur.res = {gt, eq, lt};
                end else begin
                    cur = sb_q.pop_front();
                    chk("result", {29'd0, gt, eq, lt}, {29'd0, cur.res});
                    chk("onehot", $countones({gt, eq, lt}), 1);
                    chk("latency", cyc - cur.acc, cur.lat);
                end
                seen = 1'b1;
            end else begin
                chk("hold_stable", {29'd0, gt, eq, lt}, {29'd0, cur.res});
            end
            if (out_ready) seen = 1'b0;
        end else begin
            seen = 1'b0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [2:0] res, input int lat, input bit keep);
        int   guard;
        logic rdy;
        a        = ia;
        b        = ib;
        in_valid = 1'b1;
        guard    = 0;
        do begin
            rdy = in_ready;
            tick();
            guard++;
        end while (!rdy && guard < 200);
        if (!rdy) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready never seen, got 0, expected 1");
        end else begin
            last_acc = cyc;
            sb_q.push_back('{res: res, lat: lat, acc: cyc});
        end
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_idle;
        int guard;
        guard = 0;
        while (!(in_ready && !out_valid) && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: block never returned to IDLE, in_ready=%b expected 1", in_ready);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   acc0;
        int   guard;
        int   out_before;
        // Reset state, checked before any clock edge
        #3;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", {29'd0, gt, eq, lt}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single transactions with immediate consumption
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            issue(vt[i].va, vt[i].vb, vt[i].res, lat_of(vt[i]), 1'b0);
            chk("busy_after_accept", busy, 1);
            wait_idle();
        end

        // Back-pressure: result held, new input ignored
        out_ready = 1'b0;
        issue(vt[1].va, vt[1].vb, vt[1].res, lat_of(vt[1]), 1'b0);
        guard = 0;
        while (!out_valid && guard < 50) begin
            tick();
            guard++;
        end
        chk("bp_reached_done", out_valid, 1);
        a        = 16'h0001;
        b        = 16'h0002;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_busy", busy, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_idle_in_ready", in_ready, 1);
        chk("bp_idle_out_valid", out_valid, 0);
        tick();
        chk("bp_no_accept", busy, 0);

        // Back-to-back with in_valid held
        issue(vt[0].va, vt[0].vb, vt[0].res, lat_of(vt[0]), 1'b1);
        acc0 = last_acc;
        issue(vt[1].va, vt[1].vb, vt[1].res, lat_of(vt[1]), 1'b1);
        chk("b2b_gap1", last_acc - acc0, lat_of(vt[0]) + 2);
        acc0 = last_acc;
        issue(vt[2].va, vt[2].vb, vt[2].res, lat_of(vt[2]), 1'b0);
        chk("b2b_gap2", last_acc - acc0, lat_of(vt[1]) + 2);
        wait_idle();

        // Reset asserted during the second CMP cycle
        issue(vt[2].va, vt[2].vb, vt[2].res, lat_of(vt[2]), 1'b0);
        void'(sb_q.pop_back());
        tick();
        chk("mid_busy", busy, 1);
        out_before = n_out;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_result", {29'd0, gt, eq, lt}, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("mid_rst_no_result", n_out, out_before);
        chk("mid_rst_idle", in_ready, 1);

        chk("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
